counter_nbit: RTL and testbench
===============================

# counter_nbit

Parametrised up/down/load counter replacing the fixed-width 4-, 6- and 8-bit counters in the VGA datapath (pixel/row/cell indexing, timing dividers). It adds configurable width and modulus, a step size, wrap vs. saturate behaviour, registered carry/borrow pulses for cascading, and a one-shot countdown mode with a small control FSM.

## Interface
Parameters:
- WIDTH, 8: counter width in bits, at least 2.
- MAX_VAL, 2**WIDTH-1: terminal value. The count range is 0..MAX_VAL. Legal range is 1..2**WIDTH-1.
- MODE, MODE_WRAP: one of MODE_WRAP, MODE_SAT or MODE_ONESHOT.
- STEP_W, 4: width of the step input.

Ports:
- CLK, in, 1: the single clock. All state updates on its rising edge.
- CLR_N, in, 1: reset. Reset is synchronous and active-low.
- EN, in, 1: count qualifier. `increase` and `decrease` act only when EN=1.
- increase, in, 1: add `step`.
- decrease, in, 1: subtract `step`.
- parallel, in, 1: load the value on `load`. Does not require EN.
- load, in, WIDTH: parallel load value.
- step, in, STEP_W: increment magnitude. Legal range is 0..min(MAX_VAL, 2**STEP_W-1).
- Q_OUT, out, WIDTH: current count.
- AT_MAX, out, 1: high when Q_OUT == MAX_VAL.
- AT_MIN, out, 1: high when Q_OUT == 0.
- CARRY, out, 1: one-cycle pulse. The previous increment overflowed MAX_VAL.
- BORROW, out, 1: one-cycle pulse. The previous decrement underflowed 0.
- DONE, out, 1: one-cycle pulse. A one-shot countdown reached 0.

## Operation
Command priority each cycle, highest first:
1. CLR_N=0.
2. `parallel`.
3. `increase` and `decrease` both high with EN=1: hold, no flags.
4. `increase` with EN=1.
5. `decrease` with EN=1.
6. Otherwise: hold.

Reset and load:
- On reset: Q_OUT=0, CARRY=BORROW=DONE=0, FSM goes to IDLE.
- If `load` > MAX_VAL, Q_OUT is clamped to MAX_VAL.

Arithmetic:
- All arithmetic uses WIDTH+1 bits internally. No truncation artefacts are allowed.
- Increment when Q+step > MAX_VAL:
  - MODE_WRAP: Q_OUT becomes Q+step-(MAX_VAL+1) and CARRY=1.
  - MODE_SAT: Q_OUT becomes MAX_VAL and CARRY=1.
- Decrement when step > Q:
  - MODE_WRAP: Q_OUT becomes Q+(MAX_VAL+1)-step and BORROW=1.
  - MODE_SAT: Q_OUT becomes 0 and BORROW=1.
- step=0: Q_OUT holds, no flags.
- Saturation at the limit: in MODE_SAT, incrementing again at MAX_VAL holds the value and still pulses CARRY. Decrementing at 0 behaves the same way with BORROW.

MODE_ONESHOT FSM (state register is present only in this mode):
- IDLE: `parallel` loads Q_OUT. A load value of 0 goes to DONE; a non-zero value goes to RUN. `increase` and `decrease` are ignored.
- RUN: `decrease` with EN=1 subtracts `step`, saturating at 0. The transition that makes Q_OUT=0 goes to DONE. `increase` is ignored. `parallel` reloads and stays in RUN; a reload value of 0 goes to DONE.
- DONE: lasts exactly one cycle with DONE=1, then returns to IDLE. A `parallel` in this cycle takes precedence and behaves as it does from IDLE.
- In this mode CARRY and BORROW stay 0.

## Timing
- Each command's result appears in Q_OUT in the cycle after the sampling edge. Latency is 1.
- CARRY, BORROW and DONE are registered. They are high in the same cycle as the Q_OUT value that caused them, for exactly one cycle unless the cause repeats.
- AT_MAX and AT_MIN are combinational decodes of the Q_OUT register, so they are coincident with Q_OUT.
- Reset mid-operation (any state, any command) wins. The next cycle shows Q_OUT=0, AT_MIN=1, AT_MAX=0 and all pulses 0.
- Back-to-back commands are accepted every cycle. There is no busy or stall condition.
- In a chain, driving the next stage's EN from this stage's CARRY gives a one-cycle-delayed ripple. This is accepted behaviour.

## Structure
- Shared package `counter_pkg` holds:
  - the constants MODE_WRAP=0, MODE_SAT=1, MODE_ONESHOT=2;
  - the one-shot state encoding: IDLE, RUN, DONE, 2 bits.
- One combinational sub-module, `counter_step_alu`, takes (Q, step, dir, MAX_VAL, MODE) and returns (next_q, over). It keeps the wrap/saturate arithmetic separate from the priority and FSM logic.
- Elaboration checks reject illegal settings: MAX_VAL=0, MAX_VAL ≥ 2**WIDTH, or an unknown MODE.

## Test plan
1. WIDTH=4, MAX_VAL=9, MODE_WRAP. Load 8, then increase with step=3 → Q_OUT=1 and CARRY=1 for one cycle. Then decrease with step=2 → Q_OUT=9 and BORROW=1.
2. WIDTH=6, MODE_SAT. Load 60, then increase with step=5 twice → Q_OUT=63, CARRY pulses on both cycles, AT_MAX=1.
3. Priority check. Assert parallel (load=5), increase and decrease together with EN=1 → Q_OUT=5. Then increase and decrease together → Q_OUT stays 5 with no flags. Then increase with EN=0 → Q_OUT stays 5.
4. Load 200 into WIDTH=8, MAX_VAL=150 → Q_OUT=150 and AT_MAX=1.
5. MODE_ONESHOT. Load 4, then decrease with EN=1 and step=1 for 4 cycles → Q_OUT goes 3, 2, 1, 0. DONE=1 only in the cycle Q_OUT=0, then the FSM returns to IDLE. A following increase leaves Q_OUT at 0.
6. Reset mid-run. Drop CLR_N low with Q_OUT=7 while in RUN with a decrease pending → next cycle Q_OUT=0, FSM in IDLE, all pulses 0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the counter_nbit family: counting modes and the one-shot
// countdown state encoding.
package counter_pkg;

    localparam int unsigned MODE_WRAP    = 0;
    localparam int unsigned MODE_SAT     = 1;
    localparam int unsigned MODE_ONESHOT = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } os_state_e;

endpackage

// File: rtl/counter_nbit_if.sv
// Command/status bundle between a counter_nbit and whatever drives it.
interface counter_nbit_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 4
);
    logic              EN;
    logic              increase;
    logic              decrease;
    logic              parallel;
    logic [WIDTH-1:0]  load;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  Q_OUT;
    logic              AT_MAX;
    logic              AT_MIN;
    logic              CARRY;
    logic              BORROW;
    logic              DONE;

    modport master (
        output EN, increase, decrease, parallel, load, step,
        input  Q_OUT, AT_MAX, AT_MIN, CARRY, BORROW, DONE
    );

    modport slave (
        input  EN, increase, decrease, parallel, load, step,
        output Q_OUT, AT_MAX, AT_MIN, CARRY, BORROW, DONE
    );
endinterface

// File: rtl/counter_step_alu.sv
// Combinational step arithmetic: one add or subtract of step against the count,
// with wrap or saturate at the 0..MAX_VAL bounds.
module counter_step_alu import counter_pkg::*; #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned STEP_W  = 4,
    parameter int unsigned MAX_VAL = 255,
    parameter int unsigned MODE    = MODE_WRAP
) (
    input  logic [WIDTH-1:0]  q_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              dir_i,
    output logic [WIDTH-1:0]  next_q_o,
    output logic              over_o
);
    localparam logic [WIDTH:0] MaxExt   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] Modulus  = MaxExt + (WIDTH+1)'(1);
    // One-shot countdown saturates at 0, so only wrap mode wraps.
    localparam bit             Saturate = (MODE != MODE_WRAP);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] sum;

    assign q_ext    = {1'b0, q_i};
    assign step_ext = (WIDTH+1)'(step_i);
    assign sum      = q_ext + step_ext;

    always_comb begin
        over_o = 1'b0;
        if (!dir_i) begin
            if (sum > MaxExt) begin
                over_o   = 1'b1;
                next_q_o = Saturate ? MaxExt[WIDTH-1:0] : WIDTH'(sum - Modulus);
            end else begin
                next_q_o = sum[WIDTH-1:0];
            end
        end else begin
            if (step_ext > q_ext) begin
                over_o   = 1'b1;
                next_q_o = Saturate ? '0 : WIDTH'(q_ext + Modulus - step_ext);
            end else begin
                next_q_o = WIDTH'(q_ext - step_ext);
            end
        end
    end
endmodule

// File: rtl/counter_nbit.sv
// Parametrised up/down/load counter with wrap, saturate or one-shot countdown
// behaviour and registered carry/borrow/done pulses.
module counter_nbit import counter_pkg::*; #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = (1 << WIDTH) - 1,
    parameter int unsigned MODE    = MODE_WRAP,
    parameter int unsigned STEP_W  = 4
) (
    input logic           CLK,
    input logic           CLR_N,
    counter_nbit_if.slave bus
);
    if (WIDTH < 2) begin : g_bad_width
        $error("counter_nbit: WIDTH must be at least 2");
    end
    if (MAX_VAL == 0 || longint'(MAX_VAL) >= (longint'(1) << WIDTH)) begin : g_bad_max
        $error("counter_nbit: MAX_VAL must be in 1..2**WIDTH-1");
    end
    if (MODE > MODE_ONESHOT) begin : g_bad_mode
        $error("counter_nbit: unknown MODE");
    end

    localparam logic [WIDTH-1:0] MaxQ = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] alu_q;
    logic             alu_over;
    logic             carry_q;
    logic             borrow_q;
    logic             done_q;

    assign load_clamped = (bus.load > MaxQ) ? MaxQ : bus.load;

    // Direction only matters when exactly one of increase/decrease is set.
    counter_step_alu #(
        .WIDTH   (WIDTH),
        .STEP_W  (STEP_W),
        .MAX_VAL (MAX_VAL),
        .MODE    (MODE)
    ) u_alu (
        .q_i      (q_q),
        .step_i   (bus.step),
        .dir_i    (bus.decrease),
        .next_q_o (alu_q),
        .over_o   (alu_over)
    );

    if (MODE == MODE_ONESHOT) begin : g_oneshot
        os_state_e state_q;

        always_ff @(posedge CLK) begin
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            if (!CLR_N) begin
                state_q <= StIdle;
                q_q     <= '0;
                done_q  <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (bus.parallel) begin
                    q_q <= load_clamped;
                    if (load_clamped == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StRun;
                    end
                end else begin
                    case (state_q)
                        StRun: begin
                            if (bus.EN && bus.decrease && !bus.increase) begin
                                q_q <= alu_q;
                                if (alu_q == '0 || alu_over) begin
                                    state_q <= StDone;
                                    done_q  <= 1'b1;
                                end
                            end
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end else begin : g_count
        logic [WIDTH-1:0] q_d;
        logic             carry_d;
        logic             borrow_d;

        always_comb begin
            q_d      = q_q;
            carry_d  = 1'b0;
            borrow_d = 1'b0;
            if (bus.parallel) begin
                q_d = load_clamped;
            end else if (bus.EN && bus.increase && !bus.decrease) begin
                q_d     = alu_q;
                carry_d = alu_over;
            end else if (bus.EN && bus.decrease && !bus.increase) begin
                q_d      = alu_q;
                borrow_d = alu_over;
            end
        end

        always_ff @(posedge CLK) begin
            done_q <= 1'b0;
            if (!CLR_N) begin
                q_q      <= '0;
                carry_q  <= 1'b0;
                borrow_q <= 1'b0;
            end else begin
                q_q      <= q_d;
                carry_q  <= carry_d;
                borrow_q <= borrow_d;
            end
        end
    end

    assign bus.Q_OUT  = q_q;
    assign bus.AT_MAX = (q_q == MaxQ);
    assign bus.AT_MIN = (q_q == '0);
    assign bus.CARRY  = carry_q;
    assign bus.BORROW = borrow_q;
    assign bus.DONE   = done_q;
endmodule

// File: tb/tb_counter_nbit.sv
// Bench for counter_nbit: wrap, saturate and one-shot instances driven together,
// expected outputs queued per instance and checked by an independent monitor.
module tb_counter_nbit;
    import counter_pkg::*;

    typedef struct {
        bit          clr_n;
        bit          en;
        bit          inc;
        bit          dec;
        bit          par;
        int unsigned load;
        int unsigned step;
    } stim_t;

    typedef struct {
        int unsigned q;
        bit          carry;
        bit          borrow;
        bit          done;
    } exp_t;

    logic       clk;
    logic [2:0] clr_n;

    stim_t       st[3];
    int unsigned maxv[3];
    int unsigned modev[3];
    int unsigned wmax[3];
    int unsigned smax[3];
    int unsigned mq[3];
    bit          mrun[3];
    string       name[3];
    exp_t        sb0[$];
    exp_t        sb1[$];
    exp_t        sb2[$];
    int          n_tests;
    int          n_fail;

    counter_nbit_if #(.WIDTH(4), .STEP_W(4)) bus_w ();
    counter_nbit_if #(.WIDTH(8), .STEP_W(4)) bus_s ();
    counter_nbit_if #(.WIDTH(4), .STEP_W(4)) bus_o ();

    counter_nbit #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_WRAP), .STEP_W(4)) u_wrap (
        .CLK   (clk),
        .CLR_N (clr_n[0]),
        .bus   (bus_w)
    );
    counter_nbit #(.WIDTH(8), .MAX_VAL(150), .MODE(MODE_SAT), .STEP_W(4)) u_sat (
        .CLK   (clk),
        .CLR_N (clr_n[1]),
        .bus   (bus_s)
    );
    counter_nbit #(.WIDTH(4), .MAX_VAL(15), .MODE(MODE_ONESHOT), .STEP_W(4)) u_os (
        .CLK   (clk),
        .CLR_N (clr_n[2]),
        .bus   (bus_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply();
        clr_n          = {st[2].clr_n, st[1].clr_n, st[0].clr_n};
        bus_w.EN       = st[0].en;
        bus_w.increase = st[0].inc;
        bus_w.decrease = st[0].dec;
        bus_w.parallel = st[0].par;
        bus_w.load     = st[0].load[3:0];
        bus_w.step     = st[0].step[3:0];
        bus_s.EN       = st[1].en;
        bus_s.increase = st[1].inc;
        bus_s.decrease = st[1].dec;
        bus_s.parallel = st[1].par;
        bus_s.load     = st[1].load[7:0];
        bus_s.step     = st[1].step[3:0];
        bus_o.EN       = st[2].en;
        bus_o.increase = st[2].inc;
        bus_o.decrease = st[2].dec;
        bus_o.parallel = st[2].par;
        bus_o.load     = st[2].load[3:0];
        bus_o.step     = st[2].step[3:0];
    endtask

    // Reference behaviour from the counting rules, in plain integer arithmetic.
    task automatic advance(input int k, output exp_t e);
        stim_t       s;
        int unsigned m;
        int unsigned ld;
        s        = st[k];
        m        = maxv[k];
        e.carry  = 1'b0;
        e.borrow = 1'b0;
        e.done   = 1'b0;
        ld       = (s.load > m) ? m : s.load;
        if (!s.clr_n) begin
            mq[k]   = 0;
            mrun[k] = 1'b0;
        end else if (modev[k] == MODE_ONESHOT) begin
            if (s.par) begin
                mq[k]   = ld;
                mrun[k] = (ld != 0);
                e.done  = (ld == 0);
            end else if (mrun[k] && s.en && s.dec && !s.inc) begin
                mq[k] = (s.step >= mq[k]) ? 0 : mq[k] - s.step;
                if (mq[k] == 0) begin
                    mrun[k] = 1'b0;
                    e.done  = 1'b1;
                end
            end
        end else if (s.par) begin
            mq[k] = ld;
        end else if (s.en && s.inc && !s.dec) begin
            if (mq[k] + s.step > m) begin
                e.carry = 1'b1;
                mq[k]   = (modev[k] == MODE_SAT) ? m : mq[k] + s.step - (m + 1);
            end else begin
                mq[k] = mq[k] + s.step;
            end
        end else if (s.en && s.dec && !s.inc) begin
            if (s.step > mq[k]) begin
                e.borrow = 1'b1;
                mq[k]    = (modev[k] == MODE_SAT) ? 0 : mq[k] + (m + 1) - s.step;
            end else begin
                mq[k] = mq[k] - s.step;
            end
        end
        e.q = mq[k];
    endtask

    task automatic cycle();
        exp_t e;
        apply();
        for (int k = 0; k < 3; k++) begin
            advance(k, e);
            case (k)
                0:       sb0.push_back(e);
                1:       sb1.push_back(e);
                default: sb2.push_back(e);
            endcase
        end
        @(negedge clk);
    endtask

    task automatic set(input int k, input bit rn, input bit en, input bit inc, input bit dec,
                       input bit par, input int unsigned load, input int unsigned step);
        st[k] = '{clr_n: rn, en: en, inc: inc, dec: dec, par: par, load: load, step: step};
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) set(k, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic check(input int k);
        exp_t       e;
        logic [7:0] aq;
        logic [4:0] af;
        logic [4:0] xf;
        case (k)
            0: begin
                if (sb0.size() == 0) return;
                e  = sb0.pop_front();
                aq = 8'(bus_w.Q_OUT);
                af = {bus_w.AT_MAX, bus_w.AT_MIN, bus_w.CARRY, bus_w.BORROW, bus_w.DONE};
            end
            1: begin
                if (sb1.size() == 0) return;
                e  = sb1.pop_front();
                aq = bus_s.Q_OUT;
                af = {bus_s.AT_MAX, bus_s.AT_MIN, bus_s.CARRY, bus_s.BORROW, bus_s.DONE};
            end
            default: begin
                if (sb2.size() == 0) return;
                e  = sb2.pop_front();
                aq = 8'(bus_o.Q_OUT);
                af = {bus_o.AT_MAX, bus_o.AT_MIN, bus_o.CARRY, bus_o.BORROW, bus_o.DONE};
            end
        endcase
        xf = {e.q == maxv[k], e.q == 0, e.carry, e.borrow, e.done};
        n_tests++;
        if (aq !== 8'(e.q) || af !== xf) begin
            n_fail++;
            $display("FAIL %s @%0t: Q_OUT=%0d max/min/carry/borrow/done=%b, required Q_OUT=%0d %b",
                     name[k], $time, aq, af, e.q, xf);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) check(k);
        end
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        maxv     = '{9, 150, 15};
        modev    = '{MODE_WRAP, MODE_SAT, MODE_ONESHOT};
        wmax     = '{15, 255, 15};
        smax     = '{9, 15, 15};
        name     = '{"wrap", "sat", "oneshot"};
        mq       = '{0, 0, 0};
        mrun     = '{1'b0, 1'b0, 1'b0};

        for (int k = 0; k < 3; k++) set(k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        cycle();
        cycle();

        // Wrap: 8 + 3 wraps to 1, then 1 - 2 wraps to 9.
        idle_all(); set(0, 1, 0, 0, 0, 1, 8, 0); cycle();
        idle_all(); set(0, 1, 1, 1, 0, 0, 0, 3); cycle();
        idle_all(); set(0, 1, 1, 0, 1, 0, 0, 2); cycle();
        idle_all(); cycle();
        // Priority: load beats inc/dec, inc+dec holds, EN=0 holds.
        set(0, 1, 1, 1, 1, 1, 5, 4); cycle();
        idle_all(); set(0, 1, 1, 1, 1, 0, 0, 4); cycle();
        idle_all(); set(0, 1, 0, 1, 0, 0, 0, 4); cycle();
        // Saturate: 146 + 5 + 5 sticks at 150 with carry both times; clamp 200.
        idle_all(); set(1, 1, 0, 0, 0, 1, 146, 0); cycle();
        idle_all(); set(1, 1, 1, 1, 0, 0, 0, 5); cycle();
        cycle();
        idle_all(); set(1, 1, 0, 0, 0, 1, 200, 0); cycle();
        idle_all(); set(1, 1, 0, 0, 0, 1, 0, 0); cycle();
        idle_all(); set(1, 1, 1, 0, 1, 0, 0, 3); cycle();
        cycle();
        idle_all(); set(1, 1, 1, 1, 0, 0, 0, 0); cycle();
        // One-shot: load 4, count down to 0, then increase is ignored.
        idle_all(); set(2, 1, 0, 0, 0, 1, 4, 0); cycle();
        idle_all(); set(2, 1, 1, 0, 1, 0, 0, 1);
        repeat (4) cycle();
        idle_all(); set(2, 1, 1, 1, 0, 0, 0, 1); cycle();
        // Reset during RUN with a decrease pending, then load 0 goes straight to done.
        idle_all(); set(2, 1, 0, 0, 0, 1, 7, 0); cycle();
        idle_all(); set(2, 0, 1, 0, 1, 0, 0, 2); cycle();
        idle_all(); set(2, 1, 1, 0, 1, 0, 0, 2); cycle();
        idle_all(); set(2, 1, 0, 0, 0, 1, 0, 0); cycle();
        idle_all(); cycle();

        repeat (600) begin
            for (int k = 0; k < 3; k++) begin
                st[k].clr_n = ($urandom_range(0, 29) != 0);
                st[k].par   = ($urandom_range(0, 5) == 0);
                st[k].en    = ($urandom_range(0, 3) != 0);
                st[k].inc   = $urandom_range(0, 1) == 1;
                st[k].dec   = $urandom_range(0, 1) == 1;
                st[k].load  = $urandom_range(0, wmax[k]);
                st[k].step  = $urandom_range(0, smax[k]);
            end
            cycle();
        end

        idle_all();
        cycle();
        n_tests++;
        if (sb0.size() + sb1.size() + sb2.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0",
                     sb0.size() + sb1.size() + sb2.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
